bus_transfer_arbiter: RTL and testbench

//  Shares the single 32-bit datapath bus between NUM_REQ requesters (control unit, I/O port, debug).

---
 rtl/bus_transfer_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus_transfer_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter that sequences one register-to-register move at a time
// over the shared datapath bus: IDLE -> DRIVE -> LATCH -> DONE -> IDLE.
module bus_transfer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                     i_clock,
  input  logic                     i_clear,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*SEL_W-1:0] i_src_sel,
  input  logic [NUM_REQ*SEL_W-1:0] i_dst_sel,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [NUM_REGS-1:0]      o_reg_out,
  output logic [NUM_REGS-1:0]      o_reg_in,
  output logic                     o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               r_state, w_state_nx;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nx;
  logic [IDX_W-1:0]     r_gidx, w_gidx_nx;
  logic [SEL_W-1:0]     r_src, w_src_nx;
  logic [SEL_W-1:0]     r_dst, w_dst_nx;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nx;
  logic [NUM_REQ-1:0]   r_done, w_done_nx;
  logic [NUM_REGS-1:0]  r_reg_out, w_reg_out_nx;
  logic [NUM_REGS-1:0]  r_reg_in, w_reg_in_nx;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_scan;
  logic [SEL_W-1:0]     w_pick_src;
  logic [SEL_W-1:0]     w_pick_dst;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + IDX_W'(1);
  endfunction

  // Out-of-range indices decode to all zeros, so the bus stays idle and nothing is written.
  function automatic logic [NUM_REGS-1:0] reg_dec(input logic [SEL_W-1:0] s);
    logic [NUM_REGS-1:0] d;
    d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) d[r] = (32'(s) == r);
    return d;
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [IDX_W-1:0] g);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) oh[k] = (32'(g) == k);
    return oh;
  endfunction

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first pending requester wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
      w_scan = wrap_inc(w_scan);
    end
  end

  assign w_pick_src = i_src_sel[w_pick*SEL_W +: SEL_W];
  assign w_pick_dst = i_dst_sel[w_pick*SEL_W +: SEL_W];

  always_comb begin
    w_state_nx   = r_state;
    w_rr_ptr_nx  = r_rr_ptr;
    w_gidx_nx    = r_gidx;
    w_src_nx     = r_src;
    w_dst_nx     = r_dst;
    w_grant_nx   = r_grant;
    w_done_nx    = '0;
    w_reg_out_nx = '0;
    w_reg_in_nx  = '0;
    unique case (r_state)
      IDLE: begin
        w_grant_nx = '0;
        if (w_found) begin
          w_state_nx   = DRIVE;
          w_gidx_nx    = w_pick;
          w_src_nx     = w_pick_src;
          w_dst_nx     = w_pick_dst;
          w_grant_nx   = req_onehot(w_pick);
          w_reg_out_nx = reg_dec(w_pick_src);
        end
      end
      DRIVE: begin
        w_state_nx   = LATCH;
        w_reg_out_nx = reg_dec(r_src);
        w_reg_in_nx  = reg_dec(r_dst);
      end
      LATCH: begin
        w_state_nx = DONE;
        w_done_nx  = req_onehot(r_gidx);
      end
      DONE: begin
        w_state_nx  = IDLE;
        w_grant_nx  = '0;
        w_rr_ptr_nx = wrap_inc(r_gidx);
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_clear) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_gidx    <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_reg_out <= '0;
      r_reg_in  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_rr_ptr  <= w_rr_ptr_nx;
      r_gidx    <= w_gidx_nx;
      r_src     <= w_src_nx;
      r_dst     <= w_dst_nx;
      r_grant   <= w_grant_nx;
      r_done    <= w_done_nx;
      r_reg_out <= w_reg_out_nx;
      r_reg_in  <= w_reg_in_nx;
    end
  end

  assign o_grant   = r_grant;
  assign o_done    = r_done;
  assign o_reg_out = r_reg_out;
  assign o_reg_in  = r_reg_in;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter with a behavioural 12 x 32-bit register bank on the bus.
module tb_bus_transfer_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 12;
  localparam int SW    = 4;

  logic                 clk = 1'b0;
  logic                 clear;
  logic [NREQ-1:0]      req;
  logic [NREQ*SW-1:0]   src_sel;
  logic [NREQ*SW-1:0]   dst_sel;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [NREGS-1:0]     reg_out;
  logic [NREGS-1:0]     reg_in;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] regs [NREGS];

  bus_transfer_arbiter #(.NUM_REQ(NREQ), .NUM_REGS(NREGS), .SEL_W(SW)) dut (
    .i_clock   (clk),
    .i_clear   (clear),
    .i_req     (req),
    .i_src_sel (src_sel),
    .i_dst_sel (dst_sel),
    .o_grant   (grant),
    .o_done    (done),
    .o_reg_out (reg_out),
    .o_reg_in  (reg_in),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bus_val(input logic [NREGS-1:0] sel);
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < NREGS; r++) if (sel[r]) b |= regs[r];
    return b;
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) if (reg_in[r]) regs[r] <= bus_val(reg_out);
  end

  typedef struct {
    logic              clr;
    logic [NREQ-1:0]   rq;
    logic [15:0]       src;
    logic [15:0]       dst;
    logic [NREQ-1:0]   g;
    logic [NREQ-1:0]   d;
    logic [NREGS-1:0]  o;
    logic [NREGS-1:0]  i;
    logic              b;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic clr, input logic [3:0] rq, input logic [3:0] g,
                              input logic [3:0] d, input logic [11:0] o, input logic [11:0] i,
                              input logic b);
    vec_t v;
    v.clr = clr; v.rq = rq; v.src = 16'h3210; v.dst = 16'hBA98;
    v.g = g; v.d = d; v.o = o; v.i = i; v.b = b;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] d,
                            input logic [11:0] o, input logic [11:0] i, input logic b);
    cmp({nm, ".grant"},   32'(grant),   32'(g));
    cmp({nm, ".done"},    32'(done),    32'(d));
    cmp({nm, ".reg_out"}, 32'(reg_out), 32'(o));
    cmp({nm, ".reg_in"},  32'(reg_in),  32'(i));
    cmp({nm, ".busy"},    32'(busy),    32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b0; req = '0; src_sel = '0; dst_sel = '0;
    for (int r = 0; r < NREGS; r++) regs[r] <= 32'h1000_0000 + 32'(r);

    // Reset, then round robin over all four requesters with req=1111 held.
    vecs[0]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[1]  = mk(0, 4'hF, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[2]  = mk(1, 4'hF, 4'h1, 4'h0, 12'h001, 12'h000, 1);
    vecs[3]  = mk(1, 4'hF, 4'h1, 4'h0, 12'h001, 12'h100, 1);
    vecs[4]  = mk(1, 4'hF, 4'h1, 4'h1, 12'h000, 12'h000, 1);
    vecs[5]  = mk(1, 4'hF, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[6]  = mk(1, 4'hF, 4'h2, 4'h0, 12'h002, 12'h000, 1);
    vecs[7]  = mk(1, 4'hF, 4'h2, 4'h0, 12'h002, 12'h200, 1);
    vecs[8]  = mk(1, 4'hF, 4'h2, 4'h2, 12'h000, 12'h000, 1);
    vecs[9]  = mk(1, 4'hF, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[10] = mk(1, 4'hF, 4'h4, 4'h0, 12'h004, 12'h000, 1);
    vecs[11] = mk(1, 4'hF, 4'h4, 4'h0, 12'h004, 12'h400, 1);
    vecs[12] = mk(1, 4'hF, 4'h4, 4'h4, 12'h000, 12'h000, 1);
    vecs[13] = mk(1, 4'hF, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[14] = mk(1, 4'hF, 4'h8, 4'h0, 12'h008, 12'h000, 1);
    vecs[15] = mk(1, 4'hF, 4'h8, 4'h0, 12'h008, 12'h800, 1);
    vecs[16] = mk(1, 4'hF, 4'h8, 4'h8, 12'h000, 12'h000, 1);
    vecs[17] = mk(1, 4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 0);
    vecs[18] = mk(1, 4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 0);

    for (int v = 0; v < 19; v++) begin
      clear = vecs[v].clr; req = vecs[v].rq;
      src_sel = vecs[v].src; dst_sel = vecs[v].dst;
      step();
      expect_out($sformatf("vec%0d", v), vecs[v].g, vecs[v].d, vecs[v].o, vecs[v].i, vecs[v].b);
    end

    // Single move R3 -> R7 by requester 2 (rr_ptr is back at 0).
    regs[3] <= 32'hDEADBEEF;
    req = 4'b0100; src_sel = 16'h0300; dst_sel = 16'h0700;
    step(); expect_out("mv.drive", 4'h4, 4'h0, 12'h008, 12'h000, 1);
    step(); expect_out("mv.latch", 4'h4, 4'h0, 12'h008, 12'h080, 1);
    step(); expect_out("mv.done",  4'h4, 4'h4, 12'h000, 12'h000, 1);
    req = '0;
    step(); expect_out("mv.idle",  4'h0, 4'h0, 12'h000, 12'h000, 0);
    cmp("mv.R7", regs[7], 32'hDEADBEEF);

    // Requester 1 drops req and changes src_sel while in DRIVE (rr_ptr = 3).
    req = 4'b0010; src_sel = 16'h0050; dst_sel = 16'h0060;
    step(); expect_out("drop.drive", 4'h2, 4'h0, 12'h020, 12'h000, 1);
    req = '0; src_sel = 16'h0090;
    step(); expect_out("drop.latch", 4'h2, 4'h0, 12'h020, 12'h040, 1);
    step(); expect_out("drop.done",  4'h2, 4'h2, 12'h000, 12'h000, 1);
    step(); expect_out("drop.idle",  4'h0, 4'h0, 12'h000, 12'h000, 0);
    cmp("drop.R6", regs[6], regs[5]);

    // Reset while in LATCH: outputs clear and the aborted move never writes afterwards.
    req = 4'b0100; src_sel = 16'h0100; dst_sel = 16'h0200;
    step(); expect_out("rstL.drive", 4'h4, 4'h0, 12'h002, 12'h000, 1);
    step(); expect_out("rstL.latch", 4'h4, 4'h0, 12'h002, 12'h004, 1);
    clear = 1'b0;
    step(); expect_out("rstL.reset", 4'h0, 4'h0, 12'h000, 12'h000, 0);
    clear = 1'b1; req = '0;
    for (int c = 0; c < 3; c++) begin
      step(); expect_out($sformatf("rstL.after%0d", c), 4'h0, 4'h0, 12'h000, 12'h000, 0);
    end

    // Reset while in DRIVE: destination R10 keeps its old contents (rr_ptr reset to 0).
    regs[1]  <= 32'hCAFEF00D;
    regs[10] <= 32'h12345678;
    req = 4'b0001; src_sel = 16'h0001; dst_sel = 16'h000A;
    step(); expect_out("rstD.drive", 4'h1, 4'h0, 12'h002, 12'h000, 1);
    clear = 1'b0;
    step(); expect_out("rstD.reset", 4'h0, 4'h0, 12'h000, 12'h000, 0);
    clear = 1'b1; req = '0;
    for (int c = 0; c < 3; c++) begin
      step(); expect_out($sformatf("rstD.after%0d", c), 4'h0, 4'h0, 12'h000, 12'h000, 0);
    end
    cmp("rstD.R10", regs[10], 32'h12345678);

    // src == dst = 4: register rewrites itself.
    regs[4] <= 32'h0BADF00D;
    req = 4'b0001; src_sel = 16'h0004; dst_sel = 16'h0004;
    step(); expect_out("same.drive", 4'h1, 4'h0, 12'h010, 12'h000, 1);
    step(); expect_out("same.latch", 4'h1, 4'h0, 12'h010, 12'h010, 1);
    step(); expect_out("same.done",  4'h1, 4'h1, 12'h000, 12'h000, 1);
    req = '0;
    step(); expect_out("same.idle",  4'h0, 4'h0, 12'h000, 12'h000, 0);
    cmp("same.R4", regs[4], 32'h0BADF00D);

    // dst = 15 is beyond the 12 registers: no write, sequence still completes (rr_ptr = 1).
    req = 4'b0010; src_sel = 16'h0020; dst_sel = 16'h00F0;
    step(); expect_out("oor.drive", 4'h2, 4'h0, 12'h004, 12'h000, 1);
    step(); expect_out("oor.latch", 4'h2, 4'h0, 12'h004, 12'h000, 1);
    step(); expect_out("oor.done",  4'h2, 4'h2, 12'h000, 12'h000, 1);
    req = '0;
    step(); expect_out("oor.idle",  4'h0, 4'h0, 12'h000, 12'h000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
